pio_event_master: RTL and testbench

PIO_EVENT_MASTER -- requirements
Module: pio_event_master

---
 rtl/pio_event_master.sv | 148 ++++++++++++++
 tb/tb_pio_event_master.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_event_master.sv
// Purpose: Avalon-MM master that services a 1-bit input-PIO interrupt: unmask, read level, clear edge capture, emit an event record.
// Latency: with a zero-wait slave and read latency 1, evt_valid rises 4 cycles after irq_in rises in IDLE.
// Backpressure: waitrequest holds the current command stable; a held record (evt_valid & ~evt_ready) causes new events to be dropped and counted.
module pio_event_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq_in,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        evt_level,
    output logic [7:0]  evt_count,
    output logic [7:0]  drop_count
);

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_CLR     = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    // PIO slave register map (word addresses)
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        pending_level;
    logic        cmd_accept;
    logic        commit;
    logic        out_free;
    logic        nxt_read;
    logic        nxt_write;
    logic [1:0]  nxt_address;
    logic [31:0] nxt_writedata;

    // Only bit 0 of the read data carries the PIO input level.
    logic        unused_readdata;
    assign unused_readdata = ^avm_readdata[31:1];

    // A command completes when it is actually on the bus and the slave is not stalling.
    assign cmd_accept = (avm_read | avm_write) & ~avm_waitrequest;
    // The edge-capture clear being accepted is the moment the event is committed.
    assign commit     = (state == ST_CLR) & cmd_accept;
    // The output slot can take a new record if empty or being drained this cycle.
    assign out_free   = ~evt_valid | evt_ready;

    // Next-state selection; each bus state is left only once its command is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    if (cmd_accept)           state_nxt = ST_IDLE;
            ST_IDLE:    if (irq_in && enable)     state_nxt = ST_RD;
            ST_RD:      if (cmd_accept)           state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (avm_readdatavalid)    state_nxt = ST_CLR;
            ST_CLR:     if (cmd_accept)           state_nxt = ST_GAP;
            ST_GAP:                               state_nxt = ST_IDLE;
            default:                              state_nxt = ST_INIT;
        endcase
    end

    // Command decode from the next state so the bus outputs can be registered.
    // While stalled, state_nxt equals state, so the registered command is held as-is.
    always_comb begin
        nxt_read      = 1'b0;
        nxt_write     = 1'b0;
        nxt_address   = ADDR_DATA;
        nxt_writedata = 32'd0;
        case (state_nxt)
            ST_INIT: begin
                nxt_write     = 1'b1;
                nxt_address   = ADDR_MASK;
                nxt_writedata = 32'h1;
            end
            ST_RD: begin
                nxt_read      = 1'b1;
                nxt_address   = ADDR_DATA;
            end
            ST_CLR: begin
                nxt_write     = 1'b1;
                nxt_address   = ADDR_EDGE;
                nxt_writedata = 32'h1;
            end
            default: begin
                nxt_read      = 1'b0;
                nxt_write     = 1'b0;
            end
        endcase
    end

    // State register and registered Avalon command outputs.
    // INIT's unmask write therefore appears one cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_INIT;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= 2'd0;
            avm_writedata <= 32'd0;
        end else begin
            state         <= state_nxt;
            avm_read      <= nxt_read;
            avm_write     <= nxt_write;
            avm_address   <= nxt_address;
            avm_writedata <= nxt_writedata;
        end
    end

    // Capture the sampled input level; readdatavalid in any other state is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_level <= 1'b0;
        end else if ((state == ST_RD_WAIT) && avm_readdatavalid) begin
            pending_level <= avm_readdata[0];
        end
    end

    // Event output slot: load on commit when free, otherwise drop and count; drain on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid  <= 1'b0;
            evt_level  <= 1'b0;
            evt_count  <= 8'd0;
            drop_count <= 8'd0;
        end else if (commit && out_free) begin
            evt_valid  <= 1'b1;
            evt_level  <= pending_level;
            evt_count  <= evt_count + 8'd1;
        end else begin
            if (commit && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_event_master.sv
// Bench for pio_event_master: behavioural 1-bit input PIO slave with a switch input,
// configurable waitrequest stalls, and a scoreboard of expected event records.
`timescale 1ns/1ps
module tb_pio_event_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        irq_in;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic        evt_level;
    logic [7:0]  evt_count;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       level;
        logic [7:0] count;
    } exp_t;
    exp_t       exp_q[$];
    exp_t       sb_e;
    logic [7:0] sb_cnt = 8'd0;

    always #5 clk = ~clk;

    pio_event_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .irq_in            (irq_in),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .evt_valid         (evt_valid),
        .evt_ready         (evt_ready),
        .evt_level         (evt_level),
        .evt_count         (evt_count),
        .drop_count        (drop_count)
    );

    // ---------------- PIO slave model ----------------
    logic       sw = 1'b0;
    logic       sw_d, s_mask, s_cap, s_rdv, s_rdata;
    int         wcnt;
    int         wait_n = 0;
    bit         hold_rdv = 1'b0;
    bit         inj_rdv = 1'b0;
    int         n_rd, n_wr2, n_wr3;
    bit         seen_first;
    logic [1:0] first_addr;
    logic       cmd, acc;

    assign cmd               = avm_read | avm_write;
    assign avm_waitrequest   = cmd && (wcnt < wait_n);
    assign acc               = cmd && !avm_waitrequest;
    assign avm_readdatavalid = s_rdv | inj_rdv;
    assign avm_readdata      = {31'd0, s_rdata | inj_rdv};
    assign irq_in            = s_cap & s_mask;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_d <= 1'b0; s_mask <= 1'b0; s_cap <= 1'b0; s_rdv <= 1'b0; s_rdata <= 1'b0;
            wcnt <= 0; n_rd <= 0; n_wr2 <= 0; n_wr3 <= 0; seen_first <= 1'b0; first_addr <= 2'd0;
        end else begin
            sw_d  <= sw;
            s_rdv <= acc && avm_read && !hold_rdv;
            if (acc && avm_read) s_rdata <= sw;
            wcnt  <= (cmd && !acc) ? wcnt + 1 : 0;
            if (acc && avm_write && avm_address == 2'd2) s_mask <= avm_writedata[0];
            s_cap <= (s_cap & ~(acc && avm_write && avm_address == 2'd3 && avm_writedata[0])) | (sw & ~sw_d);
            if (acc && avm_read && avm_address == 2'd0) n_rd <= n_rd + 1;
            if (acc && avm_write && avm_address == 2'd2 && avm_writedata == 32'd1) n_wr2 <= n_wr2 + 1;
            if (acc && avm_write && avm_address == 2'd3 && avm_writedata == 32'd1) n_wr3 <= n_wr3 + 1;
            if (acc && !seen_first) begin
                seen_first <= 1'b1;
                first_addr <= avm_address;
            end
        end
    end

    // ---------------- Bus protocol monitor and scoreboard ----------------
    logic        prev_pend = 1'b0;
    logic [35:0] prev_cmd;

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (avm_read && avm_write) begin
                failures++;
                $display("FAIL exclusivity: read=%b write=%b, required not both", avm_read, avm_write);
            end
            checks++;
            if (!avm_read && !avm_write && avm_writedata !== 32'd0) begin
                failures++;
                $display("FAIL idle_bus: writedata=%h, required 0", avm_writedata);
            end
            if (prev_pend) begin
                checks++;
                if ({avm_read, avm_write, avm_address, avm_writedata} !== prev_cmd) begin
                    failures++;
                    $display("FAIL cmd_hold: got %h, required %h", {avm_read, avm_write, avm_address, avm_writedata}, prev_cmd);
                end
            end
            prev_pend = cmd && avm_waitrequest;
            prev_cmd  = {avm_read, avm_write, avm_address, avm_writedata};
            if (evt_valid && evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: level=%b count=%0d, required no record", evt_level, evt_count);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (evt_level !== sb_e.level || evt_count !== sb_e.count) begin
                        failures++;
                        $display("FAIL sb_record: level=%b count=%0d, required level=%b count=%0d",
                                 evt_level, evt_count, sb_e.level, sb_e.count);
                    end
                end
            end
        end else begin
            prev_pend = 1'b0;
        end
    end

    // ---------------- Helpers ----------------
    task automatic apply_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d records outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        sb_cnt = 8'd0;
        repeat (6) @(posedge clk);
    endtask

    // Raise the switch for 'hold' cycles; the level read back is 1 only for long holds.
    task automatic do_event(input logic lvl, input int hold, input int settle, input bit serviced);
        @(posedge clk); #1;
        sw = 1'b1;
        if (serviced) begin
            sb_cnt = sb_cnt + 8'd1;
            exp_q.push_back({lvl, sb_cnt});
        end
        repeat (hold) @(posedge clk);
        #1;
        sw = 1'b0;
        repeat (settle) @(posedge clk);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata, evt_valid, evt_level, evt_count, drop_count} !== '0) begin
            failures++;
            $display("FAIL reset_state: got rd=%b wr=%b a=%0d wd=%h v=%b l=%b c=%0d d=%0d, required all 0",
                     avm_read, avm_write, avm_address, avm_writedata, evt_valid, evt_level, evt_count, drop_count);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_address !== 2'd2 || avm_writedata !== 32'h1) begin
            failures++;
            $display("FAIL init_write: rd=%b wr=%b a=%0d wd=%h, required wr=1 a=2 wd=1", avm_read, avm_write, avm_address, avm_writedata);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_wr2 != 1 || n_rd != 0 || n_wr3 != 0 || avm_read !== 1'b0 || avm_write !== 1'b0) begin
            failures++;
            $display("FAIL init_quiet: wr2=%0d rd=%0d wr3=%0d, required 1 0 0 and idle bus", n_wr2, n_rd, n_wr3);
        end
    endtask

    task automatic test_basic();
        int k;
        @(posedge clk); #1;
        sw = 1'b1;
        sb_cnt = sb_cnt + 8'd1;
        exp_q.push_back({1'b1, sb_cnt});
        for (int i = 0; i < 10 && !irq_in; i++) begin
            @(posedge clk); #1;
        end
        k = 0;
        while (!evt_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!evt_valid || k != 4) begin
            failures++;
            $display("FAIL latency: evt_valid after %0d cycles (valid=%b), required 4", k, evt_valid);
        end
        repeat (10) @(posedge clk);
        #1;
        sw = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_rd != 1 || n_wr3 != 1 || irq_in !== 1'b0 || evt_count !== 8'd1) begin
            failures++;
            $display("FAIL basic_seq: rd=%0d wr3=%0d irq=%b count=%0d, required 1 1 0 1", n_rd, n_wr3, irq_in, evt_count);
        end
    endtask

    task automatic test_waitrequest();
        wait_n = 5;
        do_event(1'b1, 24, 10, 1'b1);
        wait_n = 0;
        #1;
        checks++;
        if (evt_count !== 8'd2 || n_rd != 2 || n_wr3 != 2) begin
            failures++;
            $display("FAIL wait_event: count=%0d rd=%0d wr3=%0d, required 2 2 2", evt_count, n_rd, n_wr3);
        end
    endtask

    task automatic test_enable();
        int rd0;
        bit seen;
        @(posedge clk); #1;
        sw = 1'b1;
        sb_cnt = sb_cnt + 8'd1;
        exp_q.push_back({1'b0, sb_cnt});
        @(posedge clk); #1;
        sw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = avm_read;
        end
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (!seen || evt_count !== 8'd3 || n_wr3 != 3) begin
            failures++;
            $display("FAIL enable_finish: read_seen=%b count=%0d wr3=%0d, required 1 3 3", seen, evt_count, n_wr3);
        end
        rd0 = n_rd;
        do_event(1'b0, 1, 20, 1'b0);
        #1;
        checks++;
        if (n_rd != rd0 || avm_read !== 1'b0 || avm_write !== 1'b0) begin
            failures++;
            $display("FAIL enable_hold: reads=%0d, required %0d with idle bus", n_rd, rd0);
        end
        sb_cnt = sb_cnt + 8'd1;
        exp_q.push_back({1'b0, sb_cnt});
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_rd != rd0 + 1 || evt_count !== 8'd4) begin
            failures++;
            $display("FAIL enable_resume: reads=%0d count=%0d, required %0d 4", n_rd, evt_count, rd0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        apply_reset();
        evt_ready = 1'b0;
        do_event(1'b0, 1, 12, 1'b1);
        #1;
        checks++;
        if (evt_valid !== 1'b1 || evt_level !== 1'b0) begin
            failures++;
            $display("FAIL b2b_held: valid=%b level=%b, required 1 0", evt_valid, evt_level);
        end
        @(posedge clk); #1;
        sw = 1'b1;
        sb_cnt = sb_cnt + 8'd1;
        exp_q.push_back({1'b1, sb_cnt});
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            found = avm_write && (avm_address == 2'd3);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL b2b_timeout: clear write seen=%b, required 1", found);
        end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (evt_valid !== 1'b1 || evt_level !== 1'b1 || evt_count !== 8'd2 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL b2b_reload: valid=%b level=%b count=%0d drop=%0d, required 1 1 2 0",
                     evt_valid, evt_level, evt_count, drop_count);
        end
        @(posedge clk); #1;
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b, required 0", evt_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        sw = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_event(i[0], (i[0] ? 8 : 1), 8, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (evt_count !== 8'd0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap: count=%0d drop=%0d, required 0 0", evt_count, drop_count);
        end
    endtask

    task automatic test_drop();
        apply_reset();
        evt_ready = 1'b0;
        do_event(1'b1, 8, 8, 1'b1);
        do_event(1'b0, 1, 10, 1'b0);
        do_event(1'b0, 1, 10, 1'b0);
        #1;
        checks++;
        if (evt_valid !== 1'b1 || evt_level !== 1'b1 || evt_count !== 8'd1 || drop_count !== 8'd2) begin
            failures++;
            $display("FAIL drop_two: valid=%b level=%b count=%0d drop=%0d, required 1 1 1 2",
                     evt_valid, evt_level, evt_count, drop_count);
        end
        for (int i = 0; i < 300; i++) begin
            do_event(1'b0, 1, 10, 1'b0);
        end
        #1;
        checks++;
        if (drop_count !== 8'd255 || evt_level !== 1'b1 || evt_count !== 8'd1) begin
            failures++;
            $display("FAIL drop_sat: drop=%0d level=%b count=%0d, required 255 1 1", drop_count, evt_level, evt_count);
        end
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_drain: valid=%b, required 0", evt_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        evt_ready = 1'b1;
        hold_rdv = 1'b1;
        @(posedge clk); #1;
        sw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = avm_read;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!seen || avm_read !== 1'b0 || avm_write !== 1'b0) begin
            failures++;
            $display("FAIL rdwait_entry: read_seen=%b rd=%b wr=%b, required 1 0 0", seen, avm_read, avm_write);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata, evt_valid, evt_level, evt_count, drop_count} !== '0) begin
            failures++;
            $display("FAIL async_reset: rd=%b wr=%b a=%0d wd=%h v=%b l=%b c=%0d d=%0d, required all 0",
                     avm_read, avm_write, avm_address, avm_writedata, evt_valid, evt_level, evt_count, drop_count);
        end
        sw = 1'b0;
        hold_rdv = 1'b0;
        exp_q.delete();
        sb_cnt = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        inj_rdv = 1'b1;
        @(posedge clk); #1;
        inj_rdv = 1'b0;
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 2'd2 || avm_writedata !== 32'h1) begin
            failures++;
            $display("FAIL reinit_write: wr=%b a=%0d wd=%h, required 1 2 1", avm_write, avm_address, avm_writedata);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_wr2 != 1 || n_rd != 0 || first_addr !== 2'd2 || evt_valid !== 1'b0 || evt_count !== 8'd0) begin
            failures++;
            $display("FAIL late_rdv: wr2=%0d rd=%0d first=%0d valid=%b count=%0d, required 1 0 2 0 0",
                     n_wr2, n_rd, first_addr, evt_valid, evt_count);
        end
        do_event(1'b1, 8, 10, 1'b1);
        #1;
        checks++;
        if (evt_count !== 8'd1) begin
            failures++;
            $display("FAIL post_reset_event: count=%0d, required 1", evt_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_enable();
        test_back_to_back();
        test_wrap();
        test_drop();
        test_reset_mid_read();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_final: %0d records outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
